// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: receive-only PS/2 mouse front end.
// Synchronises and glitch-filters the PS/2 clock and deserialises 11-bit
// device-to-host frames. It assembles 3-byte movement packets and publishes
// each one on the toggle-strobed ps2_mouse bus.
// Optional build macro PS2_MOUSE_WHEEL_EN: 4-byte IntelliMouse packets, with
// the fourth byte published on ps2_wheel.
module ps2_mouse_rx #(
    parameter int          FILT    = 8,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [24:0] ps2_mouse,
    output logic [7:0]  ps2_wheel,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam logic [7:0] FILT_M1 = 8'(FILT - 1);
`ifdef PS2_MOUSE_WHEEL_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    // Odd weight over data plus parity marks a good frame.
    function automatic logic odd_weight(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic        r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic        r_clk_f;
    logic [7:0]  r_filt_cnt;
    logic [15:0] r_to_cnt;
    state_t      r_state, w_next;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_par;
    logic [1:0]  r_idx;
    logic [7:0]  r_b0, r_b1;
`ifdef PS2_MOUSE_WHEEL_EN
    logic [7:0]  r_b2;
    logic [7:0]  r_wheel;
`endif
    logic [24:0] r_mouse;
    logic        r_err;
    logic        w_fe, w_to_hit, w_to_abort, w_frame_ok, w_frame_bad;

    // Two-flop synchronisers for the asynchronous PS/2 pins (bus idles high).
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The falling edge fires on the FILT-th consecutive low sample of a high filtered clock.
    always_comb begin
        w_fe = r_clk_f && !r_clk_s2 && (r_filt_cnt == FILT_M1);
    end

    // Glitch filter: follow the synchronised clock only after FILT equal samples.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_f    <= 1'b1;
            r_filt_cnt <= 8'd0;
        end else if (r_clk_s2 == r_clk_f) begin
            r_filt_cnt <= 8'd0;
        end else if (r_filt_cnt == FILT_M1) begin
            r_clk_f    <= r_clk_s2;
            r_filt_cnt <= 8'd0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 8'd1;
        end
    end

    // Inactivity counter: cleared by every falling edge, saturates at TIMEOUT.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= 16'd0;
        end else if (w_fe) begin
            r_to_cnt <= 16'd0;
        end else if (r_to_cnt != TIMEOUT) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame FSM next state; a timeout abort always returns to IDLE.
    always_comb begin
        w_next = r_state;
        if (w_to_hit) begin
            w_next = ST_IDLE;
        end else if (w_fe) begin
            case (r_state)
                ST_IDLE:   w_next = r_dat_s2 ? ST_IDLE : ST_DATA;
                ST_DATA:   w_next = (r_bit_cnt == 3'd7) ? ST_PARITY : ST_DATA;
                ST_PARITY: w_next = ST_STOP;
                ST_STOP:   w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end else begin
            w_next = r_state;
        end
    end

    // FSM decodes: timeout event and good or bad frame completion.
    always_comb begin
        w_to_hit    = !w_fe && (r_to_cnt == (TIMEOUT - 16'd1));
        w_to_abort  = w_to_hit && ((r_state != ST_IDLE) || (r_idx != 2'd0));
        w_frame_ok  = 1'b0;
        w_frame_bad = 1'b0;
        if (w_fe && (r_state == ST_STOP)) begin
            w_frame_ok  = odd_weight(r_shift, r_par) && r_dat_s2;
            w_frame_bad = !w_frame_ok;
        end else begin
            w_frame_ok  = 1'b0;
            w_frame_bad = 1'b0;
        end
    end

    // Bit shifter: data arrives LSB first, then the parity bit.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_par     <= 1'b0;
        end else if (w_fe && (r_state == ST_IDLE)) begin
            r_bit_cnt <= 3'd0;
        end else if (w_fe && (r_state == ST_DATA)) begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end else if (w_fe && (r_state == ST_PARITY)) begin
            r_par <= r_dat_s2;
        end else begin
            r_bit_cnt <= r_bit_cnt;
        end
    end

    // Packet assembly, publication and the frame_err pulse.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_idx   <= 2'd0;
            r_b0    <= 8'd0;
            r_b1    <= 8'd0;
            r_mouse <= 25'd0;
            r_err   <= 1'b0;
`ifdef PS2_MOUSE_WHEEL_EN
            r_b2    <= 8'd0;
            r_wheel <= 8'd0;
`endif
        end else begin
            r_err <= 1'b0;
            if (w_to_abort || w_frame_bad) begin
                r_idx <= 2'd0;
                r_err <= 1'b1;
            end else if (w_frame_ok) begin
                case (r_idx)
                    2'd0: begin
                        if (r_shift[3]) begin
                            r_b0  <= r_shift;
                            r_idx <= 2'd1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    2'd1: begin
                        r_b1  <= r_shift;
                        r_idx <= 2'd2;
                    end
`ifdef PS2_MOUSE_WHEEL_EN
                    2'd2: begin
                        r_b2  <= r_shift;
                        r_idx <= 2'd3;
                    end
                    LAST_IDX: begin
                        r_mouse <= {~r_mouse[24], r_b2, r_b1, r_b0};
                        r_wheel <= r_shift;
                        r_idx   <= 2'd0;
                    end
`else
                    LAST_IDX: begin
                        r_mouse <= {~r_mouse[24], r_shift, r_b1, r_b0};
                        r_idx   <= 2'd0;
                    end
`endif
                    default: r_idx <= 2'd0;
                endcase
            end else begin
                r_idx <= r_idx;
            end
        end
    end

    assign ps2_mouse = r_mouse;
    assign frame_err = r_err;
`ifdef PS2_MOUSE_WHEEL_EN
    assign ps2_wheel = r_wheel;
`else
    assign ps2_wheel = 8'd0;
`endif

endmodule
